// File: rtl/count_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// count_sequencer_pkg
// Shared definitions for the count sequencer slice: the sequencer state
// encoding, the datapath width and the saturation limit of the zero counter.
// No ports; imported by count_sequencer and cnt4_dp.
// ---------------------------------------------------------------------------
package count_sequencer_pkg;

    localparam int DP_W = 4;

    localparam logic [DP_W-1:0] ZCNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/count_sequencer_dp.sv
// ---------------------------------------------------------------------------
// cnt4_dp
// Loadable up/down register that holds the sequencer's datapath count.
// Arithmetic is modulo 2**DP_W, so 15 + 1 = 0 and 0 - 1 = 15.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears q
//   load - write din into q (wins over en)
//   en   - step q by one in the direction given by dir
//   dir  - 0 = count up, 1 = count down
//   din  - value written on load
//   q    - current count
// ---------------------------------------------------------------------------
module cnt4_dp
    import count_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            en,
    input  logic            dir,
    input  logic [DP_W-1:0] din,
    output logic [DP_W-1:0] q
);

    // Reset clears the count; a load overrides stepping so that the seed
    // always lands cleanly. Wrap-around falls out of the fixed register width.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= dir ? (q - DP_W'(1)) : (q + DP_W'(1));
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
// Runs a seeded up/down count for a programmable number of cycles and
// counts how many of those cycles started with the count at zero.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, overrides everything
//   start    - begin a run (only honoured while idle)
//   abort    - stop the current load/run without a completion pulse
//   a        - step direction during the run, 0 = up, 1 = down
//   seed     - starting count, captured when start is accepted
//   run_len  - number of run cycles, captured when start is accepted
//   x        - current datapath count
//   zero_cnt - run cycles that began with x == 0, saturating at 15
//   busy     - high whenever the sequencer is not idle
//   done     - one-cycle pulse when a run completes normally
// ---------------------------------------------------------------------------
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             a,
    input  logic [DP_W-1:0]  seed,
    input  logic [RUN_W-1:0] run_len,
    output logic [DP_W-1:0]  x,
    output logic [DP_W-1:0]  zero_cnt,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [DP_W-1:0]  seedCap_q, seedCap_d;
    logic [RUN_W-1:0] runLen_q, runLen_d;
    logic [RUN_W-1:0] runCnt_q, runCnt_d;
    logic [DP_W-1:0]  zeroCnt_q, zeroCnt_d;
    logic [RUN_W:0]   runCntInc;
    logic             lastRun;
    logic             startOk;
    logic             stepOk;
    logic             dpLoad;

    // The run counter is compared one bit wider than its storage so the
    // final increment can never alias back to a small value.
    assign startOk   = (state_q == IDLE) && start;
    assign stepOk    = (state_q == RUN) && !abort;
    assign dpLoad    = (state_q == LOAD) && !abort;
    assign runCntInc = {1'b0, runCnt_q} + {{RUN_W{1'b0}}, 1'b1};
    assign lastRun   = (runCntInc == {1'b0, runLen_q});

    // Next-state logic. Abort is checked before run-length completion so an
    // abort on the last run cycle still returns to idle without a done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (runLen_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (lastRun) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, run-cycle counting and zero counting. The zero test
    // looks at the registered count, i.e. the value before this cycle's step.
    always_comb begin
        seedCap_d = seedCap_q;
        runLen_d  = runLen_q;
        runCnt_d  = runCnt_q;
        zeroCnt_d = zeroCnt_q;
        if (startOk) begin
            seedCap_d = seed;
            runLen_d  = run_len;
            runCnt_d  = '0;
            zeroCnt_d = '0;
        end else if (stepOk) begin
            runCnt_d = runCntInc[RUN_W-1:0];
            if ((x == '0) && (zeroCnt_q != ZCNT_MAX)) begin
                zeroCnt_d = zeroCnt_q + DP_W'(1);
            end
        end
    end

    // State and operand registers; reset returns everything to idle and
    // forgets any previously captured operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            seedCap_q <= '0;
            runLen_q  <= '0;
            runCnt_q  <= '0;
            zeroCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            seedCap_q <= seedCap_d;
            runLen_q  <= runLen_d;
            runCnt_q  <= runCnt_d;
            zeroCnt_q <= zeroCnt_d;
        end
    end

    cnt4_dp u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (dpLoad),
        .en   (stepOk),
        .dir  (a),
        .din  (seedCap_q),
        .q    (x)
    );

    assign zero_cnt = zeroCnt_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
// Self-checking bench for count_sequencer: a table of directed runs with
// hand-worked results, a few trace-level sequences, then randomized runs
// predicted by a run-level reference model.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       a;
    logic [3:0] seed;
    logic [7:0] run_len;
    logic [3:0] x;
    logic [3:0] zero_cnt;
    logic       busy;
    logic       done;

    int checkCount = 0;
    int passCount  = 0;

    int obsDone;
    int obsBusy;
    int doneAt;
    int xTrace[$];
    int modelX;

    typedef struct {
        logic [3:0]  seed;
        int          len;
        logic [63:0] aBits;
        int          abortAt;
        int          rstAt;
        int          expX;
        int          expZc;
        int          expDone;
        int          expBusy;
    } vec_t;

    vec_t vecs[11];

    count_sequencer #(.RUN_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .a        (a),
        .seed     (seed),
        .run_len  (run_len),
        .x        (x),
        .zero_cnt (zero_cnt),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: every check steps both counters here.
    task automatic checkOutput(input string name, input int got, input int want);
        checkCount++;
        if (got == want) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Run-level reference: a run is abandoned by reset (all zero) or abort
    // (count frozen after the completed run cycles), otherwise it executes
    // len steps of +1/-1 modulo 16 while tallying cycles that began at zero.
    task automatic modelRun(input logic [3:0] s, input int len, input logic [63:0] aBits,
                            input int abortAt, input int rstAt,
                            output int ex, output int ez, output int ed, output int eb);
        int v;
        int z;
        int steps;
        if ((rstAt >= 0) && ((abortAt < 0) || (rstAt <= abortAt))) begin
            ex = 0; ez = 0; ed = 0; eb = rstAt + 1;
            return;
        end
        if (abortAt == 0) begin
            ex = modelX; ez = 0; ed = 0; eb = 1;
            return;
        end
        steps = (abortAt > 0) ? abortAt - 1 : len;
        v = int'(s);
        z = 0;
        for (int i = 0; i < steps; i++) begin
            if (v == 0) z = (z >= 15) ? 15 : z + 1;
            v = aBits[i] ? (v + 15) % 16 : (v + 1) % 16;
        end
        ex = v;
        ez = z;
        ed = (abortAt > 0) ? 0 : 1;
        eb = (abortAt > 0) ? abortAt + 1 : len + 2;
    endtask

    // Starts one run and follows it cycle by cycle until the DUT is idle.
    // Cycle 0 is LOAD, cycles 1..len are RUN; abort/rst are driven in the
    // numbered cycle. Other inputs are scrambled to show they are ignored.
    task automatic applyStimulus(input logic [3:0] s, input int len, input logic [63:0] aBits,
                                 input int abortAt, input int rstAt);
        int c;
        xTrace.delete();
        obsDone = 0;
        obsBusy = 0;
        doneAt  = -1;
        start   = 1'b1;
        seed    = s;
        run_len = len[7:0];
        a       = 1'($urandom);
        abort   = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        xTrace.push_back(int'(x));
        obsBusy += int'(busy);
        if (done) begin obsDone++; doneAt = c; end
        while (busy && (c < 100)) begin
            seed    = 4'($urandom);
            run_len = 8'($urandom);
            start   = 1'($urandom);
            if ((c >= 1) && (c <= len)) a = aBits[c-1];
            else                        a = 1'($urandom);
            abort = (c == abortAt);
            rst   = (c == rstAt);
            @(posedge clk); #1;
            c++;
            xTrace.push_back(int'(x));
            obsBusy += int'(busy);
            if (done) begin obsDone++; doneAt = c; end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        if (busy) checkOutput("run_timeout", 1, 0);
    endtask

    // One idle cycle after a run: results must hold and done must stay low.
    task automatic checkHold(input string tag, input int ex, input int ez);
        @(posedge clk); #1;
        checkOutput({tag, ".holdX"}, int'(x), ex);
        checkOutput({tag, ".holdZc"}, int'(zero_cnt), ez);
    endtask

    initial begin
        int ex, ez, ed, eb;
        int rl, rAbort, rRst;
        logic [3:0]  rs;
        logic [63:0] ab;

        vecs[0]  = '{4'd0,  3,  64'h0, -1, -1, 3, 1,  1, 5};
        vecs[1]  = '{4'd7,  5,  64'h0,  0, -1, 3, 0,  0, 1};
        vecs[2]  = '{4'd14, 4,  64'h0, -1, -1, 2, 1,  1, 6};
        vecs[3]  = '{4'd1,  4,  64'hC, -1, -1, 1, 0,  1, 6};
        vecs[4]  = '{4'd0,  40, 64'h0, -1, -1, 8, 3,  1, 42};
        vecs[5]  = '{4'd0,  40, 64'h5555555555555555, -1, -1, 0, 15, 1, 42};
        vecs[6]  = '{4'd9,  0,  64'h0, -1, -1, 9, 0,  1, 2};
        vecs[7]  = '{4'd5,  6,  64'h0,  2, -1, 6, 0,  0, 3};
        vecs[8]  = '{4'd3,  2,  64'h0,  2, -1, 4, 0,  0, 3};
        vecs[9]  = '{4'd0,  8,  64'h0, -1,  3, 0, 0,  0, 4};
        vecs[10] = '{4'd6,  5,  64'h0,  2,  2, 0, 0,  0, 3};

        rst     = 1'b1;
        start   = 1'b1;
        abort   = 1'b1;
        a       = 1'b0;
        seed    = 4'd5;
        run_len = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.x", int'(x), 0);
        checkOutput("reset.zero_cnt", int'(zero_cnt), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].seed, vecs[i].len, vecs[i].aBits, vecs[i].abortAt, vecs[i].rstAt);
            checkOutput($sformatf("row%0d.x", i), int'(x), vecs[i].expX);
            checkOutput($sformatf("row%0d.zero_cnt", i), int'(zero_cnt), vecs[i].expZc);
            checkOutput($sformatf("row%0d.doneCount", i), obsDone, vecs[i].expDone);
            checkOutput($sformatf("row%0d.busyCycles", i), obsBusy, vecs[i].expBusy);
            checkHold($sformatf("row%0d", i), vecs[i].expX, vecs[i].expZc);
        end

        // Trace: seed 0, three up steps.
        applyStimulus(4'd0, 3, 64'h0, -1, -1);
        checkOutput("trace0.x1", xTrace[1], 0);
        checkOutput("trace0.x2", xTrace[2], 1);
        checkOutput("trace0.x3", xTrace[3], 2);
        checkOutput("trace0.x4", xTrace[4], 3);
        checkOutput("trace0.doneAt", doneAt, 4);

        // Trace: wrap from 15 to 0.
        applyStimulus(4'd14, 4, 64'h0, -1, -1);
        checkOutput("trace1.x2", xTrace[2], 15);
        checkOutput("trace1.x3", xTrace[3], 0);
        checkOutput("trace1.x4", xTrace[4], 1);
        checkOutput("trace1.x5", xTrace[5], 2);
        checkOutput("trace1.zero_cnt", int'(zero_cnt), 1);

        // Trace: direction change mid-run.
        applyStimulus(4'd1, 4, 64'hC, -1, -1);
        checkOutput("trace2.x2", xTrace[2], 2);
        checkOutput("trace2.x3", xTrace[3], 3);
        checkOutput("trace2.x4", xTrace[4], 2);
        checkOutput("trace2.x5", xTrace[5], 1);
        modelX = 1;

        // Randomized runs against the reference model.
        for (int r = 0; r < 40; r++) begin
            rs = 4'($urandom);
            rl = int'($urandom_range(0, 20));
            ab = {$urandom, $urandom};
            rAbort = -1;
            rRst   = -1;
            if ($urandom_range(0, 3) == 0) rAbort = int'($urandom_range(0, rl));
            if ($urandom_range(0, 7) == 0) rRst   = int'($urandom_range(0, rl));
            modelRun(rs, rl, ab, rAbort, rRst, ex, ez, ed, eb);
            applyStimulus(rs, rl, ab, rAbort, rRst);
            checkOutput($sformatf("rand%0d.x", r), int'(x), ex);
            checkOutput($sformatf("rand%0d.zero_cnt", r), int'(zero_cnt), ez);
            checkOutput($sformatf("rand%0d.doneCount", r), obsDone, ed);
            checkOutput($sformatf("rand%0d.busyCycles", r), obsBusy, eb);
            modelX = ex;
            checkHold($sformatf("rand%0d", r), ex, ez);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
